// File: rtl/status_readback_pkg.sv
// Shared types and constants for the status readback engine: FSM encoding,
// header layout and length limits.
package status_readback_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StRead,
    StDrain
  } state_e;

  localparam logic [15:0] HDR_TAG_DEFAULT = 16'hA55A;
  localparam int unsigned MAX_LEN         = 128;

  // Header word: {tag[15:0], 1'b0, addr[6:0], len[7:0], seq[15:0], 16'h0000}
  localparam int unsigned HDR_TAG_LSB  = 48;
  localparam int unsigned HDR_ADDR_LSB = 40;
  localparam int unsigned HDR_LEN_LSB  = 32;
  localparam int unsigned HDR_SEQ_LSB  = 16;

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    return (len > 8'(MAX_LEN)) ? 8'(MAX_LEN) : len;
  endfunction

  function automatic logic [63:0] make_hdr(input logic [15:0] tag, input logic [6:0] addr,
                                           input logic [7:0] len, input logic [15:0] seq);
    logic [63:0] hdr;
    hdr = '0;
    hdr[HDR_TAG_LSB +: 16] = tag;
    hdr[HDR_ADDR_LSB +: 7] = addr;
    hdr[HDR_LEN_LSB +: 8]  = len;
    hdr[HDR_SEQ_LSB +: 16] = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/status_rd_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible whenever
// the FIFO is not empty.
module status_rd_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/status_readback.sv
// Status RAM readback engine: on request, emits a header word then the
// requested RAM words as a framed stream, with credit-based flow control.
module status_readback
  import status_readback_pkg::*;
#(
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] HDR_TAG    = HDR_TAG_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_addr,
  input  logic [7:0]  req_len,
  output logic [6:0]  status_ram_addr,
  output logic        status_ram_rd_en,
  input  logic [63:0] status_ram_data,
  input  logic        status_ram_data_vld,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic        err_unexp
);

  localparam int unsigned CW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_LIMIT = (CW + 1)'(FIFO_DEPTH);

  state_e            r_state, w_state_nxt;
  logic [6:0]        r_addr, r_rd_addr;
  logic [7:0]        r_len, r_remaining;
  logic [15:0]       r_seq;
  logic [CW-1:0]     r_inflight;
  logic [RD_LAT-1:0] r_tag_pipe;
  logic              r_err;

  logic              w_accept, w_hdr_push, w_issue, w_issue_last, w_frame_done;
  logic              w_credit, w_vld_ok, w_vld_bad, w_push, w_pop;
  logic [64:0]       w_push_data, w_fifo_head;
  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_empty, w_fifo_full;

  // Reserve a FIFO slot for every word already pushed or still in the RAM pipe.
  assign w_credit     = ({1'b0, w_fifo_count} + {1'b0, r_inflight}) < DEPTH_LIMIT;
  assign w_vld_ok     = status_ram_data_vld & (r_inflight != '0);
  assign w_vld_bad    = status_ram_data_vld & (r_inflight == '0);
  assign w_pop        = ~w_fifo_empty & m_ready;
  assign w_issue_last = w_issue & (r_remaining == 8'd1);
  assign w_push       = w_hdr_push | w_vld_ok;
  assign w_push_data  = w_hdr_push ? {(r_len == 8'd0), make_hdr(HDR_TAG, r_addr, r_len, r_seq)}
                                   : {r_tag_pipe[RD_LAT-1], status_ram_data};

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_hdr_push   = 1'b0;
    w_issue      = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = StHdr;
        end
      end
      StHdr: begin
        if (w_credit) begin
          w_hdr_push  = 1'b1;
          w_state_nxt = (r_len == 8'd0) ? StDrain : StRead;
        end
      end
      StRead: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_remaining == 8'd1) w_state_nxt = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && w_fifo_head[64]) begin
          w_frame_done = 1'b1;
          w_state_nxt  = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_len       <= '0;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_seq       <= '0;
      r_inflight  <= '0;
      r_tag_pipe  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= req_addr;
        r_len  <= clamp_len(req_len);
      end
      if (w_hdr_push) begin
        r_rd_addr   <= r_addr;
        r_remaining <= r_len;
      end
      if (w_issue) begin
        r_rd_addr   <= r_rd_addr + 7'd1;
        r_remaining <= r_remaining - 8'd1;
      end
      case ({w_issue, w_vld_ok})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      r_tag_pipe[0] <= w_issue_last;
      for (int i = 1; i < RD_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
      if (w_frame_done) r_seq <= r_seq + 16'd1;
      if (w_vld_bad) r_err <= 1'b1;
    end
  end

  status_rd_fifo #(
    .WIDTH (65),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (sys_clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // Credit accounting must make a push into a full FIFO impossible.
  assert property (@(posedge sys_clk) disable iff (!rst_n) !(w_push && w_fifo_full));

  assign req_ready        = (r_state == StIdle);
  assign busy             = (r_state != StIdle);
  assign status_ram_rd_en = w_issue;
  assign status_ram_addr  = r_rd_addr;
  assign m_valid          = ~w_fifo_empty;
  assign m_last           = ~w_fifo_empty & w_fifo_head[64];
  assign m_data           = w_fifo_empty ? 64'd0 : w_fifo_head[63:0];
  assign err_unexp        = r_err;

endmodule

// File: doc/status_readback.md
STATUS_READBACK -- requirements
Module: status_readback

Interface
REQ-001 Parameter RD_LAT, default 2: status RAM read latency in clocks, from status_ram_rd_en to status_ram_data_vld.
REQ-002 Parameter FIFO_DEPTH, default 4: output buffer depth in words; minimum RD_LAT+1.
REQ-003 Parameter HDR_TAG, default 16'hA55A: frame header marker.
REQ-004 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  readback request strobe.
REQ-007 req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-008 req_addr  in  7  start word address.
REQ-009 req_len  in  8  word count, valid range 1..128.
REQ-010 status_ram_addr  out  7  status RAM read address.
REQ-011 status_ram_rd_en  out  1  one-cycle read strobe, one per word.
REQ-012 status_ram_data  in  64  read data.
REQ-013 status_ram_data_vld  in  1  read data valid, RD_LAT cycles after rd_en.
REQ-014 m_data  out  64  output stream word.
REQ-015 m_valid  out  1  output word valid.
REQ-016 m_ready  in  1  downstream accept.
REQ-017 m_last  out  1  marks the final word of a frame.
REQ-018 busy  out  1  high in any state except IDLE.
REQ-019 err_unexp  out  1  sticky flag: vld seen with no read in flight.

Function
REQ-020 FSM states: IDLE, HDR, READ, DRAIN.
REQ-021 IDLE->HDR on request accept; req_addr and the clamped length are latched at accept.
REQ-022 Length clamping: req_len=0 gives a header-only frame; req_len>128 is treated as 128.
REQ-023 HDR pushes one header word {HDR_TAG, 1'b0, addr[6:0], len[7:0], seq[15:0], 16'h0000} when credit is available.
REQ-024 After the header push: go to READ if len>0, otherwise go to DRAIN with the header tagged last.
REQ-025 Credit rule: a FIFO push or a read issue is allowed only when fifo_count + inflight < FIFO_DEPTH, so the FIFO never overflows.
REQ-026 READ issues at most one rd_en per cycle while credit allows.
REQ-027 The read address starts at the latched addr and increments modulo 128 (127 wraps to 0).
REQ-028 READ->DRAIN in the cycle the final read is issued.
REQ-029 Each issued read carries a last tag through an RD_LAT-deep shift register, aligned with status_ram_data_vld.
REQ-030 On status_ram_data_vld, {tag, status_ram_data} is pushed into the FIFO unconditionally; credit guarantees space.
REQ-031 The inflight counter increments on rd_en and decrements on vld; a simultaneous increment and decrement leaves it unchanged.
REQ-032 A vld with inflight=0 is discarded and sets err_unexp; only reset clears err_unexp.
REQ-033 Output is a first-word-fall-through FIFO head: m_valid = FIFO not empty; m_data and m_last come from the head entry.
REQ-034 A pop occurs on m_valid & m_ready; a push and pop in the same cycle keeps the count unchanged.
REQ-035 DRAIN->IDLE in the cycle after the word with m_last is accepted.
REQ-036 seq (16 bits) increments by 1 at each frame completion and wraps at 0xFFFF->0.
REQ-037 Frame latency with m_ready held high: header at m_valid 2 cycles after accept; first data word RD_LAT cycles after the first rd_en plus 1 FIFO cycle.
REQ-038 m_ready held low stalls issue via credit; no data is lost or duplicated.
REQ-039 req_valid outside IDLE is ignored; it is neither queued nor acknowledged.

Reset
REQ-040 rst_n low asynchronously clears: state=IDLE, FIFO empty, inflight=0, tag pipe=0, seq=0, err_unexp=0.
REQ-041 During and after reset, outputs are 0: m_valid, m_last, m_data, status_ram_rd_en, status_ram_addr, busy.
REQ-042 req_ready is 1 after reset.
REQ-043 Reset mid-frame drops the frame; after reset, vld still arriving from the RAM is discarded and sets err_unexp.

Structure
REQ-044 A shared package holds: state encoding, HDR_TAG, header field offsets, MAX_LEN=128.
REQ-045 One sub-module, status_rd_fifo: synchronous FWFT FIFO, 65 bits wide, FIFO_DEPTH entries, exposing count/empty/full.

Verification
REQ-046 Scenario: addr=0, len=5, m_ready=1 -> header with addr 0 / len 5 / seq 0, then RAM words 0..4, m_last on word 4; busy low afterwards.
REQ-047 Scenario: addr=126, len=4 -> reads at addresses 126, 127, 0, 1 in order.
REQ-048 Scenario: len=128, m_ready toggling randomly 50% -> 129 words, no loss or duplicate, FIFO never overflows, inflight never exceeds FIFO_DEPTH.
REQ-049 Scenario: len=0, then len=200 -> first frame is a header-only word with m_last set; second frame has 128 data words; seq values are 0 then 1.
REQ-050 Scenario: rst_n low mid-READ, then a new request -> all outputs 0 during reset; the next frame starts with seq=0; a stale vld sets err_unexp.
REQ-051 Scenario: vld injected while IDLE -> no push to the FIFO, err_unexp=1 sticky.
